// File: rtl/scroll_ctrl.sv
// Scroll sequencer for the six-digit HEX marquee.
// Produces the scroll position sel for the per-digit pattern muxes. It supports
// run/pause, single-step on key edges, scroll direction and four speed settings.
module scroll_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int POSITIONS = 6
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       run,
  input  logic       dir,
  input  logic       step_req,
  input  logic [1:0] speed,
  output logic [2:0] sel,
  output logic       tick,
  output logic [1:0] state
);

  // Prescaler count never exceeds TICK_DIV-1, so clog2(TICK_DIV) bits are enough.
  localparam int          CW       = $clog2(TICK_DIV);
  localparam logic [31:0] DIV      = 32'(TICK_DIV);
  localparam logic [2:0]  LAST_POS = 3'(POSITIONS - 1);

  typedef enum logic [1:0] {
    ST_PAUSE   = 2'b00,
    ST_RUN     = 2'b01,
    ST_STEP    = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [2:0]    r_sel;
  logic          r_tick;
  logic          r_prev;

  logic          w_edge;
  logic [31:0]   w_period;
  logic [31:0]   w_countExt;
  logic          w_terminal;
  logic          w_advance;
  logic [2:0]    w_selNext;

  // The period is re-evaluated every cycle; a >= compare lets a shortened
  // period wrap immediately instead of counting past the new terminal value.
  assign w_period   = DIV >> speed;
  assign w_countExt = 32'(r_count);
  assign w_terminal = (w_countExt >= (w_period - 32'd1));

  // A step key edge is a rising level seen against last cycle's sample.
  assign w_edge = step_req & ~r_prev;

  // Only STEP and a terminal count while still running move the position;
  // dropping run in the same cycle as a terminal count wins over the advance.
  assign w_advance = (r_state == ST_STEP) ||
                     ((r_state == ST_RUN) && run && w_terminal);

  // Next position wraps at both ends so sel stays inside 0..POSITIONS-1.
  always_comb begin
    w_selNext = r_sel;
    if (dir) begin
      w_selNext = (r_sel == 3'd0) ? LAST_POS : (r_sel - 3'd1);
    end else begin
      w_selNext = (r_sel == LAST_POS) ? 3'd0 : (r_sel + 3'd1);
    end
  end

  // Sequencer FSM with prescaler, position register, tick pulse and key edge
  // register; prev resets to 1 so a key held through reset is not a step.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_state <= ST_PAUSE;
      r_count <= '0;
      r_sel   <= 3'd0;
      r_tick  <= 1'b0;
      r_prev  <= 1'b1;
    end else begin
      r_prev <= step_req;
      r_tick <= w_advance;
      if (w_advance) begin
        r_sel <= w_selNext;
      end
      case (r_state)
        ST_PAUSE: begin
          r_count <= '0;
          if (run) begin
            r_state <= ST_RUN;
          end else if (w_edge) begin
            r_state <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (!run) begin
            r_state <= ST_PAUSE;
            r_count <= '0;
          end else if (w_terminal) begin
            r_count <= '0;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        ST_STEP: begin
          r_count <= '0;
          r_state <= ST_PAUSE;
        end
        default: begin
          r_count <= '0;
          r_state <= ST_PAUSE;
        end
      endcase
    end
  end

  assign sel   = r_sel;
  assign tick  = r_tick;
  assign state = r_state;

endmodule

// File: tb/tb_scroll_ctrl.sv
// Self-checking bench for scroll_ctrl with a cycle-level behavioural model.
module tb_scroll_ctrl;

  localparam int TDIV = 8;
  localparam int NPOS = 6;

  logic       clk      = 1'b0;
  logic       aclr     = 1'b0;
  logic       run      = 1'b0;
  logic       dir      = 1'b0;
  logic       step_req = 1'b0;
  logic [1:0] speed    = 2'd0;
  logic [2:0] sel;
  logic       tick;
  logic [1:0] state;

  int testCount = 0;
  int failCount = 0;
  bit checkEn   = 1'b0;

  // Behavioural model: mode 0 pause, 1 run, 2 step; elapsed counts cycles spent running.
  int mMode    = 0;
  int mElapsed = 0;
  int mSel     = 0;
  int mTick    = 0;
  bit mPrev    = 1'b1;

  scroll_ctrl #(.TICK_DIV(TDIV), .POSITIONS(NPOS)) dut (
    .clk      (clk),
    .aclr     (aclr),
    .run      (run),
    .dir      (dir),
    .step_req (step_req),
    .speed    (speed),
    .sel      (sel),
    .tick     (tick),
    .state    (state)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit iRun, input bit iDir, input bit iStep, input logic [1:0] iSpeed);
    @(negedge clk);
    run      = iRun;
    dir      = iDir;
    step_req = iStep;
    speed    = iSpeed;
  endtask

  // Model advances one clock: a run of P cycles earns one step; STEP always steps once.
  always @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      mMode = 0; mElapsed = 0; mSel = 0; mTick = 0; mPrev = 1'b1;
    end else begin
      automatic bit keyEdge = step_req && !mPrev;
      automatic bit adv     = 1'b0;
      automatic int period  = TDIV >> speed;
      case (mMode)
        0: begin
          mElapsed = 0;
          if (run) mMode = 1;
          else if (keyEdge) mMode = 2;
        end
        1: begin
          if (!run) begin
            mMode = 0;
            mElapsed = 0;
          end else begin
            mElapsed++;
            if (mElapsed >= period) begin
              adv = 1'b1;
              mElapsed = 0;
            end
          end
        end
        default: begin
          adv = 1'b1;
          mMode = 0;
          mElapsed = 0;
        end
      endcase
      if (adv) mSel = dir ? (mSel + NPOS - 1) % NPOS : (mSel + 1) % NPOS;
      mTick = adv ? 1 : 0;
      mPrev = step_req;
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cyc_sel", int'(sel), mSel);
      checkOutput("cyc_tick", int'(tick), mTick);
      checkOutput("cyc_state", int'(state), mMode);
    end
  end

  // Waits (bounded) for RUN to show, then counts cycles until sel changes.
  task automatic measureFirstAdvance(output int cycles);
    automatic int guard = 0;
    automatic logic [2:0] startSel;
    while (state !== 2'b01 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("run_entry_timeout", (guard < 20) ? 1 : 0, 1);
    startSel = sel;
    cycles = 0;
    while (sel === startSel && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    automatic int cycles;
    automatic int stepCycles;
    automatic int s0;
    automatic int guard;
    automatic int r;

    // Reset and hold in pause
    repeat (3) @(negedge clk);
    aclr = 1'b1;
    checkEn = 1'b1;
    checkOutput("rst_sel", int'(sel), 0);
    checkOutput("rst_state", int'(state), 0);
    checkOutput("rst_tick", int'(tick), 0);
    repeat (50) applyStimulus(0, 0, 0, 2'd0);
    checkOutput("hold_sel", int'(sel), 0);

    // Forward run at speed 0: first change 8 cycles after RUN shows
    applyStimulus(1, 0, 0, 2'd0);
    measureFirstAdvance(cycles);
    checkOutput("fwd_first_latency", cycles, 8);
    checkOutput("fwd_first_sel", int'(sel), 1);
    checkOutput("fwd_first_tick", int'(tick), 1);
    repeat (40) @(negedge clk);
    checkOutput("fwd_wrap_sel", int'(sel), 0);
    checkOutput("fwd_wrap_tick", int'(tick), 1);

    // Backward at speed 2, then jump to speed 3 mid-count
    applyStimulus(1, 1, 0, 2'd2);
    repeat (11) @(negedge clk);
    applyStimulus(1, 1, 0, 2'd3);
    repeat (3) @(negedge clk);
    checkOutput("spd3_tick", int'(tick), 1);
    repeat (10) @(negedge clk);

    // Single steps in pause, key held 20 cycles per press
    applyStimulus(0, 0, 0, 2'd0);
    repeat (3) @(negedge clk);
    checkOutput("pause_state", int'(state), 0);
    s0 = int'(sel);
    stepCycles = 0;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 20; c++) begin
        applyStimulus(0, 0, 1, 2'd0);
        if (state === 2'b10) stepCycles++;
      end
      for (int c = 0; c < 5; c++) begin
        applyStimulus(0, 0, 0, 2'd0);
        if (state === 2'b10) stepCycles++;
      end
    end
    checkOutput("step_state_cycles", stepCycles, 3);
    checkOutput("step_sel", int'(sel), (s0 + 3) % NPOS);

    // run and key edge together in pause: RUN, no immediate advance
    s0 = int'(sel);
    applyStimulus(1, 0, 1, 2'd0);
    @(negedge clk);
    checkOutput("sim_state", int'(state), 1);
    checkOutput("sim_tick", int'(tick), 0);
    checkOutput("sim_sel", int'(sel), s0);
    // Key edges during RUN are ignored
    for (int k = 0; k < 6; k++) applyStimulus(1, 0, k[0], 2'd0);
    // Pause then restart: full period again
    applyStimulus(0, 0, 0, 2'd0);
    applyStimulus(0, 0, 0, 2'd0);
    applyStimulus(1, 0, 0, 2'd0);
    measureFirstAdvance(cycles);
    checkOutput("restart_latency", cycles, 8);

    // Reset mid-run at sel=4 with the key held across reset
    guard = 0;
    while (sel !== 3'd4 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("reach_sel4_timeout", (guard < 100) ? 1 : 0, 1);
    repeat (3) @(negedge clk);
    step_req = 1'b1;
    @(posedge clk);
    #2 aclr = 1'b0;
    #1;
    checkOutput("arst_sel", int'(sel), 0);
    checkOutput("arst_tick", int'(tick), 0);
    checkOutput("arst_state", int'(state), 0);
    applyStimulus(0, 0, 1, 2'd0);
    aclr = 1'b1;
    repeat (10) applyStimulus(0, 0, 1, 2'd0);
    checkOutput("arst_nostep_sel", int'(sel), 0);
    checkOutput("arst_nostep_state", int'(state), 0);

    // Randomized operation against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 99));
      if (r < 3) run = ~run;
      else if (r < 12) step_req = ~step_req;
      else if (r < 15) dir = ~dir;
      else if (r < 18) speed = 2'($urandom_range(0, 3));
    end

    @(negedge clk);
    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/scroll_ctrl.md
Name: scroll_ctrl

Overview:
Sequencer for the six-digit HEX marquee. It produces the scroll position `sel`, which drives the per-digit 6:1 pattern muxes. It replaces the free-running prescaler and position counter pair with a controlled block that supports:
- run/pause,
- single-step,
- scroll direction,
- four speed settings.

It sits between the board switches/keys and the mux/decoder datapath.

Parameters:
- TICK_DIV, 50000000, clock cycles per scroll step at speed 0; must be >= 8.
- POSITIONS, 6, number of scroll positions; `sel` counts 0..POSITIONS-1; must be in 2..8.

Ports:
- clk       input   1  system clock (CLOCK_50 domain)
- aclr      input   1  asynchronous active-low reset
- run       input   1  level; 1 = auto-scroll, 0 = pause
- dir       input   1  0 = forward (sel increments), 1 = backward (sel decrements)
- step_req  input   1  level from a debounced key; each 0->1 edge requests one step while paused
- speed     input   2  step period = TICK_DIV >> speed (speed 3 = 8x faster than speed 0)
- sel       output  3  current scroll position, to the mux select inputs
- tick      output  1  one-cycle pulse, high in the first cycle `sel` shows a new value
- state     output  2  FSM state: 00 PAUSE, 01 RUN, 10 STEP

Behaviour:
- Reset (aclr=0, asynchronous):
  - sel=0, tick=0, state=PAUSE (00);
  - prescaler count=0;
  - step edge register prev=1, so a key held through reset does not cause a step.
- Prescaler:
  - count runs 0..P-1 only in RUN, where P = TICK_DIV >> speed, evaluated every cycle.
  - Terminal condition is count >= P-1, so lowering the period mid-count wraps on the next cycle instead of overrunning.
  - At terminal: count <= 0 and an advance is issued.
  - Outside RUN, count is held at 0.
- Step edge: edge = step_req & ~prev, with prev <= step_req every cycle.
- FSM:
  - PAUSE: run=1 -> RUN. Otherwise, edge=1 -> STEP.
  - PAUSE, run=1 and edge=1 in the same cycle: RUN is taken and the edge is discarded.
  - RUN: run=0 -> PAUSE; count clears on that edge. Step edges are ignored in RUN.
  - RUN: a terminal count issues an advance and the FSM stays in RUN.
  - STEP: lasts exactly one cycle, issues one advance, then goes to PAUSE unconditionally, even if run=1. RUN is entered from PAUSE on the following cycle.
  - Illegal state encoding (11) -> PAUSE.
- Advance:
  - dir is sampled in the advancing cycle.
  - Forward: sel = POSITIONS-1 ? 0 : sel+1.
  - Backward: sel = 0 ? POSITIONS-1 : sel-1.
  - sel never leaves 0..POSITIONS-1.
- tick:
  - Registered; tick=1 exactly in the cycle after the advancing edge, aligned with the new sel value. Otherwise tick=0.
- Latency:
  - Step key edge to sel change: 2 clocks (edge detect, then STEP advance).
  - RUN entry to first advance: P cycles.
- Asynchronous reset mid-operation returns all outputs to reset values immediately. No step is pending after release.

Test Plan:
1. Reset and hold: TICK_DIV=8, POSITIONS=6, aclr low then high, run=0 -> sel=0, state=00, tick never pulses over 50 cycles.
2. Forward run: run=1, dir=0, speed=0 -> sel steps 0,1,2,3,4,5,0 every 8 cycles. tick is high 1 cycle per change. First change occurs 8 cycles after state=01.
3. Backward run at speed 2: dir=1, speed=2 -> period 2 cycles, sel 0,5,4,3... Switching speed 0->3 mid-count wraps within 1 cycle and never exceeds a 1-cycle period.
4. Single step: in PAUSE, pulse step_req high for 20 cycles, 3 times, dir=0 -> sel 0->1->2->3. state shows 10 for exactly 1 cycle per press. Holding the key generates no extra steps.
5. Simultaneous/ignored events:
   - run and a step edge arrive in the same cycle in PAUSE -> RUN, no immediate advance.
   - Step edges during RUN -> no extra advance.
   - run=0 during RUN -> PAUSE, and the next run=1 restarts the full 8-cycle period.
6. Reset mid-run: aclr pulsed low while sel=4 and count mid-period -> sel=0, tick=0, state=00 asynchronously. A step_req held high across reset causes no step after release.
